pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
//   Sits between the CC_PLL instances and the per-clock-domain counter logic. Watches the
//   asynchronous USR_PLL_LOCKED flags, requires a stable lock, then releases one active-low
//   reset per domain in a staggered order. Drops all domain resets on any lock loss.
//   Pulses a PLL reset request after a lock timeout, retries, and flags a sticky failure.
// PARAMETERS
//   NUM_PLL        4        number of PLL lock inputs / domain reset outputs (1..8)
//   STABLE_CYCLES  1024     consecutive clk cycles all locks must hold before release
//   STEP_CYCLES    256      clk cycles between successive rst_n_out bit releases
//   TIMEOUT_CYCLES 1000000  clk cycles allowed in WAIT_LOCK before a retry
//   RETRY_PULSE    16       width of pll_rst_req pulse, in clk cycles
//   MAX_RETRIES    3        retries before entering FAIL (<=15)
// PORTS
//   clk         in   1        reference clock (board oscillator, not a PLL output)
//   rst         in   1        asynchronous, active-low reset
//   pll_locked  in   NUM_PLL  USR_PLL_LOCKED from each PLL, asynchronous to clk
//   rst_n_out   out  NUM_PLL  per-domain active-low reset, bit k for PLL k
//   all_ready   out  1        high while in RUN
//   pll_rst_req out  1        drives USR_LOCKED_STDY_RST of all PLLs
//   lock_fail   out  1        sticky: retries exhausted
//   retry_cnt   out  4        retries performed since last RUN entry
// BEHAVIOUR
//   - Reset (rst low): state=WAIT_LOCK; rst_n_out=0, all_ready=0, pll_rst_req=0, lock_fail=0,
//     retry_cnt=0, all timers=0, sync flops=0. All outputs are registered.
//   - Each pll_locked bit passes through a 2-FF synchronizer. The FSM acts on the AND of the
//     synced bits ("locked"). Latency: input to FSM decision is 3 edges.
//   - WAIT_LOCK: timer increments each cycle. If locked: go to STABLE, counter=0. Else, if
//     timer==TIMEOUT_CYCLES-1: go to RETRY if retry_cnt<MAX_RETRIES, otherwise go to FAIL.
//   - STABLE: counter increments. If !locked: go to WAIT_LOCK, timer=0. Else, if
//     counter==STABLE_CYCLES-1: go to RELEASE; set rst_n_out[0]=1 on the same edge, idx=1,
//     step=0.
//   - RELEASE: step increments. When step==STEP_CYCLES-1: set rst_n_out[idx]=1, idx++,
//     step=0. On the edge after rst_n_out[NUM_PLL-1] rises: go to RUN; all_ready=1,
//     retry_cnt=0.
//   - RUN: hold. Released bits stay 1. Bits are released strictly in index order.
//   - Lock loss in RELEASE or RUN (!locked): on the next edge rst_n_out=0 and all_ready=0
//     (all bits at once), go to WAIT_LOCK with timer=0. No retry is charged.
//   - RETRY: pll_rst_req=1 for exactly RETRY_PULSE cycles, and retry_cnt++ on entry. Then
//     pll_rst_req=0, go to WAIT_LOCK with timer=0. Locks are ignored during RETRY.
//   - FAIL: lock_fail=1, rst_n_out=0, pll_rst_req=0. Terminal; only rst exits.
//   - Simultaneous events: lock loss has priority over timer expiry.
//     Timeout and lock arriving on the same edge: lock wins.
//   - Async rst mid-sequence clears everything immediately, with no glitch on rst_n_out
//     (it only falls).
//   - Counter widths: $clog2 of the respective parameter. No wrap-around is possible,
//     because every counter is cleared on compare.
// TESTING (NUM_PLL=4, STABLE=8, STEP=4, TIMEOUT=32, RETRY_PULSE=4, MAX_RETRIES=2)
//   1 all pll_locked=1 before edge 1 after rst release -> rst_n_out[0..3] rise at edges
//     11/15/19/23; all_ready=1 at edge 24.
//   2 lock bit 2 drops for 1 cycle mid-STABLE -> back to WAIT_LOCK; full STABLE count restarts
//     and rst_n_out stays 0 meanwhile.
//   3 in RUN, drop pll_locked[1] -> rst_n_out=4'b0000 and all_ready=0 three edges later;
//     relock -> full sequence repeats.
//   4 locks never assert -> pll_rst_req high at edges 32..35 (retry_cnt=1), again after the
//     next 32-cycle wait (retry_cnt=2); on the 3rd timeout lock_fail=1 and stays set.
//   5 assert rst while in RELEASE with rst_n_out=4'b0011 -> all outputs 0 immediately;
//     sequence restarts cleanly after release.
//   6 locks arrive during a RETRY pulse -> ignored until WAIT_LOCK; RUN reached with
//     retry_cnt cleared to 0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Purpose : sequences per-domain active-low resets from synchronised PLL lock flags, with lock-timeout retry and sticky failure.
// Latency : a lock input change reaches an FSM decision on the 3rd clk edge; every output is a flop.
// Backpressure: none; pll_locked is sampled every cycle and a lock loss overrides any timer.
//
// Ports:
//   clk          reference clock (board oscillator, never a PLL output)
//   rst          asynchronous active-low reset
//   pll_locked   per-PLL lock flags, asynchronous to clk
//   rst_n_out    per-domain active-low reset, bit k belongs to PLL k
//   all_ready    high while every domain is released and locks hold
//   pll_rst_req  reset request pulse to all PLLs after a lock timeout
//   lock_fail    sticky: retries exhausted, cleared only by rst
//   retry_cnt    retries performed since the last time all domains ran
module pll_reset_sequencer #(
    parameter int NUM_PLL        = 4,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STEP_CYCLES    = 256,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RETRY_PULSE    = 16,
    parameter int MAX_RETRIES    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_PLL-1:0] pll_locked,
    output logic [NUM_PLL-1:0] rst_n_out,
    output logic               all_ready,
    output logic               pll_rst_req,
    output logic               lock_fail,
    output logic [3:0]         retry_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int PW = (STEP_CYCLES    > 1) ? $clog2(STEP_CYCLES)    : 1;
    localparam int RW = (RETRY_PULSE    > 1) ? $clog2(RETRY_PULSE)    : 1;
    localparam int CW_A = (TW > SW) ? TW : SW;
    localparam int CW_B = (PW > RW) ? PW : RW;
    localparam int CW   = (CW_A > CW_B) ? CW_A : CW_B;

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST    = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(RETRY_PULSE - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        RETRY,
        FAIL
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [NUM_PLL-1:0]   rst_n_nxt;
    logic [3:0]           retry_nxt;
    logic [NUM_PLL-1:0]   sync1, sync2;
    logic                 locked;

    // Two-flop synchronizer per lock bit; the FSM only trusts all of them together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pll_locked;
            sync2 <= sync1;
        end
    end

    assign locked = &sync2;

    // One cycle counter serves as the wait timer, stability counter, release
    // step counter and pulse counter: only one of them is live in any state,
    // and it is cleared on every state change and on every compare hit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        rst_n_nxt = rst_n_out;
        retry_nxt = retry_cnt;
        case (state)
            WAIT_LOCK: begin
                // A lock seen on the timeout edge wins over the timeout.
                if (locked) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt = '0;
                    if (retry_cnt < RETRY_MAX) begin
                        state_nxt = RETRY;
                        retry_nxt = retry_cnt + 4'd1;
                    end else begin
                        state_nxt = FAIL;
                    end
                end
            end
            STABLE: begin
                if (!locked) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RELEASE;
                    rst_n_nxt = NUM_PLL'(1);
                    cnt_nxt   = '0;
                end
            end
            RELEASE: begin
                if (!locked) begin
                    state_nxt = WAIT_LOCK;
                    rst_n_nxt = '0;
                    cnt_nxt   = '0;
                end else if (rst_n_out[NUM_PLL-1]) begin
                    state_nxt = RUN;
                    retry_nxt = 4'd0;
                    cnt_nxt   = '0;
                end else if (cnt == STEP_LAST) begin
                    // rst_n_out is a thermometer code from bit 0 upwards, so
                    // shifting in a one releases exactly the next domain.
                    rst_n_nxt = (rst_n_out << 1) | NUM_PLL'(1);
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = cnt;
                if (!locked) begin
                    state_nxt = WAIT_LOCK;
                    rst_n_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
            RETRY: begin
                // Lock flags are deliberately ignored while the PLLs are held in reset.
                if (cnt == PULSE_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            FAIL: begin
                cnt_nxt   = cnt;
                rst_n_nxt = '0;
            end
            default: begin
                state_nxt = WAIT_LOCK;
                rst_n_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Status outputs are registered copies of the next state, so they change
    // on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            rst_n_out   <= '0;
            all_ready   <= 1'b0;
            pll_rst_req <= 1'b0;
            lock_fail   <= 1'b0;
            retry_cnt   <= 4'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rst_n_out   <= rst_n_nxt;
            all_ready   <= (state_nxt == RUN);
            pll_rst_req <= (state_nxt == RETRY);
            lock_fail   <= (state_nxt == FAIL);
            retry_cnt   <= retry_nxt;
        end
    end

endmodule
